// File: rtl/approx_err_monitor.sv
// approx_err_monitor: error statistics for the approximate Sklansky adder; define APXERR_SQED_EN to add an ED^2 accumulator (sqed_sum)
module approx_err_monitor #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     n_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          op_a,
   input  logic [15:0]          op_b,
   input  logic [15:0]          apx_sum,
   input  logic                 apx_cout,
   output logic                 done,
   output logic                 busy,
   output logic [CNT_W-1:0]     samp_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [17+CNT_W-1:0]  ed_sum,
   output logic [16:0]          ed_max
`ifdef APXERR_SQED_EN
   ,
   output logic [34+CNT_W-1:0]  sqed_sum
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     n_q, n_d, acc_q, acc_d, samp_q, samp_d, err_q, err_d;
   logic [17+CNT_W-1:0]  sum_q, sum_d;
   logic [16:0]          max_q, max_d, ed1_q, ed1_d;
   logic                 v1_q, v1_d;
   logic [16:0]          exact, approx;
   logic                 accept, go;
`ifdef APXERR_SQED_EN
   logic [34+CNT_W-1:0]  sq_q, sq_d;
   logic [33:0]          ed_sq;
`endif
   always_comb begin
      exact    = {1'b0, op_a} + {1'b0, op_b};
      approx   = {apx_cout, apx_sum};
      in_ready = (state_q == RUN) && (acc_q < n_q);
      accept   = in_valid && in_ready;
      go       = start && (state_q == IDLE || state_q == DONE);
      v1_d     = accept;
      ed1_d    = exact >= approx ? exact - approx : approx - exact;
      n_d      = go ? n_samples : n_q;
      acc_d    = go ? '0 : acc_q + CNT_W'(accept);
      // The pipeline is always empty in IDLE/DONE, so go never races a stage-2 update
      samp_d   = go ? '0 : samp_q + CNT_W'(v1_q);
      err_d    = go ? '0 : err_q + CNT_W'(v1_q && ed1_q != '0);
      sum_d    = go ? '0 : sum_q + (v1_q ? (17+CNT_W)'(ed1_q) : '0);
      max_d    = go ? '0 : (v1_q && ed1_q > max_q) ? ed1_q : max_q;
      state_d  = go ? RUN :
                 (state_q == RUN && acc_d == n_q) ? DRAIN :
                 (state_q == DRAIN && !v1_q) ? DONE : state_q;
`ifdef APXERR_SQED_EN
      ed_sq    = 34'(ed1_q) * 34'(ed1_q);
      sq_d     = go ? '0 : sq_q + (v1_q ? (34+CNT_W)'(ed_sq) : '0);
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         acc_q   <= '0;
         v1_q    <= 1'b0;
         ed1_q   <= '0;
         samp_q  <= '0;
         err_q   <= '0;
         sum_q   <= '0;
         max_q   <= '0;
`ifdef APXERR_SQED_EN
         sq_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         v1_q    <= v1_d;
         ed1_q   <= ed1_d;
         samp_q  <= samp_d;
         err_q   <= err_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
`ifdef APXERR_SQED_EN
         sq_q    <= sq_d;
`endif
      end
   end
   assign done     = state_q == DONE;
   assign busy     = state_q == RUN || state_q == DRAIN;
   assign samp_cnt = samp_q;
   assign err_cnt  = err_q;
   assign ed_sum   = sum_q;
   assign ed_max   = max_q;
`ifdef APXERR_SQED_EN
   assign sqed_sum = sq_q;
`endif
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: directed and random checks of approx_err_monitor
module tb_approx_err_monitor;
   logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, apx_cout = 0;
   logic [15:0] n_samples = 0, op_a = 0, op_b = 0, apx_sum = 0;
   logic        in_ready, done, busy;
   logic [15:0] samp_cnt, err_cnt;
   logic [32:0] ed_sum;
   logic [16:0] ed_max;
`ifdef APXERR_SQED_EN
   logic [49:0] sqed_sum;
`endif
   int errors = 0, checks = 0, stalls = 0;

   approx_err_monitor #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
      .apx_sum(apx_sum), .apx_cout(apx_cout), .done(done), .busy(busy),
      .samp_cnt(samp_cnt), .err_cnt(err_cnt), .ed_sum(ed_sum), .ed_max(ed_max)
`ifdef APXERR_SQED_EN
      , .sqed_sum(sqed_sum)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // Bit-accurate approximate adder: low 4 sum bits see only the neighbour's generate
   function automatic logic [16:0] apx(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] g, p;
      logic [3:0]  lo;
      logic [12:0] hi;
      g = a & b;
      p = a ^ b;
      lo[0] = p[0];
      for (int i = 1; i < 4; i++) lo[i] = p[i] ^ g[i-1];
      hi = {1'b0, a[15:4]} + {1'b0, b[15:4]} + {12'b0, g[3]};
      return {hi, lo};
   endfunction

   task automatic start_run(input logic [15:0] n);
      start = 1; n_samples = n;
      @(negedge clk);
      start = 0;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
      int w = 0;
      in_valid = 1; op_a = a; op_b = b; {apx_cout, apx_sum} = s;
      while (!in_ready && w < 200) begin @(negedge clk); w++; end
      stalls += w;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready got %0b want 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin @(negedge clk); cyc++; end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL wait_done got done=%0b want 1 within %0d cycles", done, budget); end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (2) @(negedge clk);
      checks++; if ({done, busy, in_ready} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {done, busy, in_ready}); end
      checks++; if ({samp_cnt, err_cnt, ed_sum, ed_max} !== '0) begin errors++; $display("FAIL reset_acc got %h want 0", {samp_cnt, err_cnt, ed_sum, ed_max}); end
      rst_n = 1;
      start_run(5);
      send(16'h000F, 16'h0001, 17'h0000C);
      send(16'h000F, 16'h0001, 17'h0000C);
      send(16'h000F, 16'h0001, 17'h0000C);
      in_valid = 0;
      checks++; if (samp_cnt !== 16'd2) begin errors++; $display("FAIL midrun_cnt got %0d want 2", samp_cnt); end
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      checks++; if ({done, busy, in_ready} !== 3'b000) begin errors++; $display("FAIL midrst_ctl got %b want 000", {done, busy, in_ready}); end
      checks++; if ({samp_cnt, err_cnt, ed_sum, ed_max} !== '0) begin errors++; $display("FAIL midrst_acc got %h want 0", {samp_cnt, err_cnt, ed_sum, ed_max}); end
      @(negedge clk);
      checks++; if (samp_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL post_rst got cnt=%0d busy=%0b want 0 0", samp_cnt, busy); end
   endtask

   task automatic test_single();
      start_run(1);
      send(16'h000F, 16'h0001, 17'h0000C);
      in_valid = 0;
      checks++; if ({busy, done, in_ready} !== 3'b100) begin errors++; $display("FAIL single_k got %b want 100", {busy, done, in_ready}); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || samp_cnt !== 16'd1) begin errors++; $display("FAIL single_k1 got done=%0b cnt=%0d want 0 1", done, samp_cnt); end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %0b want 1", done); end
      checks++; if (err_cnt !== 16'd1 || ed_sum !== 33'd4 || ed_max !== 17'd4) begin errors++; $display("FAIL single_res got err=%0d sum=%0d max=%0d want 1 4 4", err_cnt, ed_sum, ed_max); end
      in_valid = 1;
      repeat (4) @(negedge clk);
      in_valid = 0;
      checks++; if (samp_cnt !== 16'd1 || done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL single_hold got cnt=%0d done=%0b rdy=%0b want 1 1 0", samp_cnt, done, in_ready); end
   endtask

   task automatic test_back_to_back();
      int c;
      start_run(3);
      stalls = 0;
      send(16'h0003, 16'h0001, 17'h00000);
      send(16'h1230, 16'h0450, 17'h01680);
      send(16'h000F, 16'h0001, 17'h0000C);
      in_valid = 0;
      checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %0b want 0", in_ready); end
      wait_done(5, c);
      checks++; if (c !== 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", c); end
      checks++; if (samp_cnt !== 16'd3 || err_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt got %0d/%0d want 3/2", samp_cnt, err_cnt); end
      checks++; if (ed_sum !== 33'd8 || ed_max !== 17'd4) begin errors++; $display("FAIL b2b_ed got sum=%0d max=%0d want 8 4", ed_sum, ed_max); end
   endtask

   task automatic test_worst();
      int c;
      start_run(2);
      checks++; if (samp_cnt !== 16'd0 || ed_max !== 17'd0 || ed_sum !== 33'd0) begin errors++; $display("FAIL start_clear got cnt=%0d max=%0d sum=%0d want 0 0 0", samp_cnt, ed_max, ed_sum); end
      send(16'hFFFF, 16'hFFFF, 17'h00000);
      send(16'h0000, 16'h0000, 17'h00005);
      in_valid = 0;
      wait_done(5, c);
      checks++; if (samp_cnt !== 16'd2 || err_cnt !== 16'd2) begin errors++; $display("FAIL worst_cnt got %0d/%0d want 2/2", samp_cnt, err_cnt); end
      checks++; if (ed_max !== 17'h1FFFE) begin errors++; $display("FAIL worst_max got %h want 1fffe", ed_max); end
      checks++; if (ed_sum !== 33'h20003) begin errors++; $display("FAIL worst_sum got %h want 20003", ed_sum); end
`ifdef APXERR_SQED_EN
      checks++; if (sqed_sum !== 50'h3FFF8001D) begin errors++; $display("FAIL worst_sqed got %h want 3fff8001d", sqed_sum); end
`endif
   endtask

   task automatic test_zero_restart();
      int c;
      start_run(0);
      wait_done(3, c);
      checks++; if (c !== 2) begin errors++; $display("FAIL zero_latency got %0d want 2", c); end
      checks++; if ({samp_cnt, err_cnt, ed_sum, ed_max} !== '0) begin errors++; $display("FAIL zero_res got %h want 0", {samp_cnt, err_cnt, ed_sum, ed_max}); end
      start_run(4);
      repeat (5) @(negedge clk);
      checks++; if ({busy, in_ready, done} !== 3'b110) begin errors++; $display("FAIL idle_run got %b want 110", {busy, in_ready, done}); end
      start_run(0);
      repeat (2) @(negedge clk);
      checks++; if ({busy, in_ready, done} !== 3'b110) begin errors++; $display("FAIL run_start_ignored got %b want 110", {busy, in_ready, done}); end
      for (int i = 0; i < 4; i++) send(16'h0100, 16'h0200, 17'h00300);
      in_valid = 0;
      wait_done(5, c);
      checks++; if (samp_cnt !== 16'd4 || err_cnt !== 16'd0 || ed_sum !== 33'd0) begin errors++; $display("FAIL restart_res got cnt=%0d err=%0d sum=%0d want 4 0 0", samp_cnt, err_cnt, ed_sum); end
   endtask

   task automatic test_random();
      int c, m_err = 0;
      longint m_sum = 0, m_sq = 0;
      logic [16:0] m_max = 0, ex, s, ed;
      logic [15:0] a, b;
      start_run(16'd1000);
      for (int i = 0; i < 1000; i++) begin
         in_valid = 0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         a = 16'($urandom);
         b = 16'($urandom);
         ex = {1'b0, a} + {1'b0, b};
         s = ($urandom_range(0, 3) == 0) ? ex : apx(a, b);
         ed = ex > s ? ex - s : s - ex;
         m_err += (ed != 0) ? 1 : 0;
         m_sum += longint'(ed);
         m_sq += longint'(ed) * longint'(ed);
         if (ed > m_max) m_max = ed;
         send(a, b, s);
      end
      in_valid = 0;
      wait_done(5, c);
      checks++; if (samp_cnt !== 16'd1000) begin errors++; $display("FAIL rand_cnt got %0d want 1000", samp_cnt); end
      checks++; if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL rand_err got %0d want %0d", err_cnt, m_err); end
      checks++; if (ed_sum !== 33'(m_sum)) begin errors++; $display("FAIL rand_sum got %0d want %0d", ed_sum, m_sum); end
      checks++; if (ed_max !== m_max) begin errors++; $display("FAIL rand_max got %h want %h", ed_max, m_max); end
`ifdef APXERR_SQED_EN
      checks++; if (sqed_sum !== 50'(m_sq)) begin errors++; $display("FAIL rand_sqed got %0d want %0d", sqed_sum, m_sq); end
`endif
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_worst();
      test_zero_restart();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
